// File: rtl/sort4_ctrl.sv
// Four-entry bubble sorter: loads four 4-bit values, sorts them ascending
// with a single shared comparator (one compare per cycle), then streams them out.
module sort4_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] swap_cnt
);

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] data_buf [4];
  logic [1:0]        idx;
  logic [1:0]        j;
  logic [1:0]        j_pair;
  logic [1:0]        pass;
  logic              flag;
  logic [3:0]        swap_q;
  logic              done_q;

  logic [DATA_W-1:0] cmp_a;
  logic [DATA_W-1:0] cmp_b;
  logic [DATA_W:0]   cmp_diff;
  logic              a_lt_b;
  logic              a_eq_b;
  logic              a_gt_b;

  logic              load_fire;
  logic              out_fire;
  logic              pass_end;
  logic              pass_swapped;
  logic              sort_exit;

  // The only magnitude comparator: one subtraction yields lt, eq and gt.
  assign j_pair   = j + 2'd1;
  assign cmp_a    = data_buf[j];
  assign cmp_b    = data_buf[j_pair];
  assign cmp_diff = {1'b0, cmp_a} - {1'b0, cmp_b};
  assign a_lt_b   = cmp_diff[DATA_W];
  assign a_eq_b   = (cmp_diff[DATA_W-1:0] == '0);
  assign a_gt_b   = !a_lt_b && !a_eq_b;

  assign load_fire    = (state == LOAD) && in_valid;
  assign out_fire     = (state == OUT) && out_ready;
  assign pass_end     = (j == 2'd2);
  assign pass_swapped = flag || a_gt_b;
  assign sort_exit    = pass_end && (!pass_swapped || (pass == 2'd2));

  assign out_data = data_buf[idx];
  assign swap_cnt = swap_q;
  assign done     = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (load_fire && (idx == 2'd3)) state_nxt = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (sort_exit) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_fire && (idx == 2'd3)) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) data_buf[i] <= '0;
      idx    <= 2'd0;
      j      <= 2'd0;
      pass   <= 2'd0;
      flag   <= 1'b0;
      swap_q <= 4'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == SORT) && sort_exit;
      case (state)
        LOAD: begin
          if (load_fire) begin
            data_buf[idx] <= in_data;
            idx           <= idx + 2'd1;
            if (idx == 2'd0) swap_q <= 4'd0;
            if (idx == 2'd3) begin
              j    <= 2'd0;
              pass <= 2'd0;
              flag <= 1'b0;
            end
          end
        end
        SORT: begin
          if (a_gt_b) begin
            data_buf[j]      <= cmp_b;
            data_buf[j_pair] <= cmp_a;
            if (swap_q != 4'hF) swap_q <= swap_q + 4'd1;
          end
          // Pass boundary: flag restarts so each pass judges its own swaps.
          if (pass_end) begin
            j    <= 2'd0;
            flag <= 1'b0;
            pass <= sort_exit ? 2'd0 : pass + 2'd1;
          end else begin
            j <= j + 2'd1;
            if (a_gt_b) flag <= 1'b1;
          end
        end
        OUT: begin
          if (out_fire) idx <= idx + 2'd1;
        end
        default: begin
          idx <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  producer presents in_data.
REQ-004 in_data  input  4  unsigned operand to load.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 out_valid  output  1  out_data holds a sorted element.
REQ-007 out_data  output  4  sorted element, ascending order.
REQ-008 out_ready  input  1  consumer accepts out_data.
REQ-009 busy  output  1  high while in SORT.
REQ-010 done  output  1  one-cycle pulse on the SORT->OUT transition.
REQ-011 swap_cnt  output  4  number of swaps performed for the current set (0..6).

Function
REQ-012 The block SHALL hold buf[0..3] (4 bits each), a 2-bit load/output index, a 2-bit pair index j, a 2-bit pass counter, and a pass-swap flag.
REQ-013 The block SHALL contain exactly one 4-bit magnitude comparator (gt/lt/eq), with A = buf[j] and B = buf[j+1]; no other magnitude compare is permitted.
REQ-014 The state machine SHALL have states LOAD, SORT and OUT; reset state is LOAD.
REQ-015 LOAD: in_ready = 1; a transfer occurs on in_valid && in_ready, writes buf[idx], and increments idx.
REQ-016 The first transfer of a set SHALL clear swap_cnt to 0 in the same edge.
REQ-017 The 4th transfer (idx = 3) SHALL move the FSM to SORT, with j = 0, pass = 0, idx = 0, and the flag cleared.
REQ-018 SORT: each cycle SHALL perform one compare.
REQ-019 On A_gt_B, buf[j] and buf[j+1] SHALL swap, swap_cnt SHALL increment, and the flag SHALL be set.
REQ-020 Equal or less SHALL cause no swap, so equal values stay in place.
REQ-021 j SHALL step 0->1->2; at j = 2 the pass ends.
REQ-022 End of pass: if no swap occurred in the pass (including the j = 2 compare), or pass = 2, the FSM SHALL go to OUT; otherwise pass increments, j = 0, and the flag is cleared.
REQ-023 SORT latency SHALL be 3 cycles per pass, minimum 3 (already sorted) and maximum 9 (3 passes).
REQ-024 done SHALL be asserted in the cycle the FSM leaves SORT, registered so it is high for exactly one cycle, in the first OUT cycle.
REQ-025 OUT: out_valid = 1 and out_data = buf[idx]; on out_valid && out_ready, idx increments.
REQ-026 After the 4th output handshake, the FSM SHALL return to LOAD with idx = 0.
REQ-027 out_data SHALL stay stable while out_valid && !out_ready.
REQ-028 in_ready SHALL be 0 in SORT and OUT; in_valid is ignored there.
REQ-029 out_valid SHALL be 0 in LOAD and SORT; out_ready is ignored there.
REQ-030 swap_cnt SHALL hold its final value through OUT and the following LOAD until the next first transfer.
REQ-031 The maximum swap count is 6 (reversed input); the 4-bit width SHALL not wrap.

Reset
REQ-032 rst_n low SHALL immediately, asynchronously and in any state, force: FSM = LOAD; idx, j, pass, flag = 0; buf[] = 0; swap_cnt = 0; in_ready = 1 (combinational from state); out_valid, busy, done = 0.
REQ-033 Reset during SORT or OUT SHALL abandon the set; no partial output follows reset release.
REQ-034 The first transfer after reset release SHALL be written to buf[0].

Verification
REQ-035 Load 3,2,1,0 with out_ready = 1 -> busy for 9 cycles, swap_cnt = 6, done pulse, outputs 0,1,2,3.
REQ-036 Load 1,2,3,4 -> busy for exactly 3 cycles, swap_cnt = 0, outputs 1,2,3,4.
REQ-037 Load 5,5,2,5 -> swap_cnt = 2, outputs 2,5,5,5, no swap on equal pairs.
REQ-038 Load 15,0,15,0 with out_ready toggled 1/0 -> outputs 0,0,15,15, out_data stable while stalled, in_ready = 0 until the last output handshake.
REQ-039 Assert rst_n low in the 2nd SORT cycle of 3,2,1,0 -> all outputs reset at once; after release, load 7,6,9,8 -> outputs 6,7,8,9 with swap_cnt = 2.
REQ-040 Drive in_valid = 1 during SORT and OUT -> no change to buf[] and no change to the output sequence.
